// File: rtl/row_nz_serializer_pkg.sv
// Shared constants and types for the row compressor / row serializer pair.
// Holds the default row geometry (word width, words per row, index width,
// row tag width) and the serializer state encoding.
package row_nz_serializer_pkg;

    localparam int DEF_WORD_WIDTH   = 8;
    localparam int DEF_MAX_R_SIZE   = 4;
    localparam int DEF_R_DIST_WIDTH = 2;
    localparam int DEF_ROW_ID_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/row_nz_serializer_lsb_priority_encoder.sv
// lsb_priority_encoder: finds the lowest set bit of a mask.
// Ports:
//   mask   - input bit mask (WIDTH bits)
//   idx    - index of the lowest set bit (0 when mask is zero)
//   found  - mask has at least one bit set
//   single - mask has exactly one bit set
// Purely combinational; shared with the row compressor.
module lsb_priority_encoder
    import row_nz_serializer_pkg::*;
#(
    parameter int WIDTH     = DEF_MAX_R_SIZE,
    parameter int IDX_WIDTH = DEF_R_DIST_WIDTH
) (
    input  logic [WIDTH-1:0]     mask,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 found,
    output logic                 single
);

    // Scan upward; the first set bit wins and later bits are ignored.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i] && !found) begin
                idx   = IDX_WIDTH'(i);
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
        // Clearing the lowest set bit leaves zero only for a one-hot mask.
        single = found && ((mask & (mask - WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/row_nz_serializer.sv
// row_nz_serializer: accepts one packed row per handshake and emits only its
// nonzero words, lowest index first, one per beat, each tagged with its
// original position and a per-row tag.
// Ports:
//   clk, reset_n          - clock (rising edge), async active-low reset
//   in_valid/in_ready     - row handshake; data_in is the packed row
//   out_valid/out_ready   - beat handshake
//   out_data, out_idx     - nonzero word and its position in the row
//   out_last              - final beat of the current row
//   out_row_id            - tag of the row this beat belongs to
// Optional feature: define RNZS_ZERO_ROW_BEAT_EN to make an all-zero row
// produce one marker beat (data 0, idx 0, last) instead of no beats.
module row_nz_serializer
    import row_nz_serializer_pkg::*;
#(
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int MAX_R_SIZE   = DEF_MAX_R_SIZE,
    parameter int R_DIST_WIDTH = DEF_R_DIST_WIDTH,
    parameter int ROW_ID_WIDTH = DEF_ROW_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_WIDTH*MAX_R_SIZE-1:0] data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_WIDTH-1:0]        out_data,
    output logic [R_DIST_WIDTH-1:0]      out_idx,
    output logic                         out_last,
    output logic [ROW_ID_WIDTH-1:0]      out_row_id
);

    state_e                          state_r, state_nxt_s;
    logic [MAX_R_SIZE-1:0]           mask_r, mask_nxt_s;
    logic [WORD_WIDTH*MAX_R_SIZE-1:0] row_r, row_nxt_s;
    logic [ROW_ID_WIDTH-1:0]         tag_r, tag_nxt_s;
    logic [ROW_ID_WIDTH-1:0]         cnt_r, cnt_nxt_s;

    logic [R_DIST_WIDTH-1:0]         enc_idx_s;
    logic                            enc_found_s;
    logic                            enc_single_s;
    logic [MAX_R_SIZE-1:0]           load_mask_s;
    logic [WORD_WIDTH-1:0]           sel_word_s;
    logic                            emit_s;
    logic                            fire_s;
    logic                            accept_s;

    lsb_priority_encoder #(
        .WIDTH     (MAX_R_SIZE),
        .IDX_WIDTH (R_DIST_WIDTH)
    ) u_enc (
        .mask   (mask_r),
        .idx    (enc_idx_s),
        .found  (enc_found_s),
        .single (enc_single_s)
    );

    // Nonzero-word mask of the incoming row, used when the row is latched.
    always_comb begin
        load_mask_s = '0;
        for (int i = 0; i < MAX_R_SIZE; i++) begin
            load_mask_s[i] = (data_in[i*WORD_WIDTH +: WORD_WIDTH] != '0);
        end
`ifdef RNZS_ZERO_ROW_BEAT_EN
        // An empty row emits word 0 (which is zero) as a single marker beat.
        if (load_mask_s == '0) begin
            load_mask_s = MAX_R_SIZE'(1);
        end else begin
            load_mask_s = load_mask_s;
        end
`endif
    end

    // Select the latched word at the current lowest pending position.
    always_comb begin
        sel_word_s = '0;
        for (int i = 0; i < MAX_R_SIZE; i++) begin
            if (enc_idx_s == R_DIST_WIDTH'(i)) begin
                sel_word_s = row_r[i*WORD_WIDTH +: WORD_WIDTH];
            end else begin
                sel_word_s = sel_word_s;
            end
        end
    end

    // Handshake decode and beat outputs, all derived from state registers
    // except the intentional out_ready -> in_ready reload path.
    always_comb begin
        emit_s     = (state_r == ST_EMIT) && enc_found_s;
        fire_s     = emit_s && out_ready;
        in_ready   = (state_r == ST_IDLE) || (emit_s && enc_single_s && out_ready);
        accept_s   = in_valid && in_ready;
        out_valid  = emit_s;
        out_data   = emit_s ? sel_word_s : '0;
        out_idx    = emit_s ? enc_idx_s : '0;
        out_last   = emit_s && enc_single_s;
        out_row_id = emit_s ? tag_r : '0;
    end

    // Next-state: a new row (possibly reloaded on the last beat) takes
    // priority over retiring the current beat.
    always_comb begin
        state_nxt_s = state_r;
        mask_nxt_s  = mask_r;
        row_nxt_s   = row_r;
        tag_nxt_s   = tag_r;
        cnt_nxt_s   = cnt_r;
        if (accept_s) begin
            row_nxt_s   = data_in;
            mask_nxt_s  = load_mask_s;
            tag_nxt_s   = cnt_r;
            cnt_nxt_s   = cnt_r + ROW_ID_WIDTH'(1);
            state_nxt_s = (load_mask_s != '0) ? ST_EMIT : ST_IDLE;
        end else if (fire_s) begin
            mask_nxt_s  = mask_r & ~(MAX_R_SIZE'(1) << enc_idx_s);
            state_nxt_s = enc_single_s ? ST_IDLE : ST_EMIT;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State registers; reset discards any row in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            mask_r  <= '0;
            row_r   <= '0;
            tag_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            mask_r  <= mask_nxt_s;
            row_r   <= row_nxt_s;
            tag_r   <= tag_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_row_nz_serializer.sv
// Self-checking bench for row_nz_serializer: table-driven row streams with
// hand-computed beats, plus hand-written stall, wrap, reset and random runs.
module tb_row_nz_serializer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic [7:0]  out_row_id;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] rid;
        logic       last;
        logic [1:0] idx;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        logic [7:0] w [4];
        int         n;
        logic [7:0] d [4];
        logic [1:0] ix [4];
    } vec_t;

    logic [31:0] feed_q [$];
    beat_t       exp_q [$];
    vec_t        tbl [$];

    row_nz_serializer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_row_id (out_row_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkrow(input logic [7:0] w0, input logic [7:0] w1,
                                          input logic [7:0] w2, input logic [7:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Expected beats of one row computed word by word.
    task automatic model_row(input logic [31:0] row, input logic [7:0] rid);
        int    last_i;
        beat_t b;
        last_i = -1;
        for (int i = 0; i < 4; i++) if (row[8*i +: 8] != 8'd0) last_i = i;
        for (int i = 0; i < 4; i++) begin
            if (row[8*i +: 8] != 8'd0) begin
                b.data = row[8*i +: 8];
                b.idx  = 2'(i);
                b.last = (i == last_i);
                b.rid  = rid;
                exp_q.push_back(b);
            end
        end
`ifdef RNZS_ZERO_ROW_BEAT_EN
        if (last_i < 0) begin
            b = '{rid: rid, last: 1'b1, idx: 2'd0, data: 8'd0};
            exp_q.push_back(b);
        end
`endif
    endtask

    task automatic load_table(input int base_rid);
        beat_t b;
        for (int k = 0; k < tbl.size(); k++) begin
            feed_q.push_back(mkrow(tbl[k].w[0], tbl[k].w[1], tbl[k].w[2], tbl[k].w[3]));
            for (int j = 0; j < tbl[k].n; j++) begin
                b.data = tbl[k].d[j];
                b.idx  = tbl[k].ix[j];
                b.last = (j == tbl[k].n - 1);
                b.rid  = 8'(base_rid + k);
                exp_q.push_back(b);
            end
        end
        tbl.delete();
    endtask

    // Drive feed_q back to back and compare every handshaken beat.
    task automatic run(input int ready_rand, input int budget, output int nvalid, output int span);
        int    cyc;
        int    first;
        int    last_c;
        beat_t got;
        cyc = 0; first = -1; last_c = -1; nvalid = 0;
        while ((feed_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            out_ready = (ready_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (feed_q.size() != 0) begin
                in_valid = 1'b1;
                data_in  = feed_q[0];
            end else begin
                in_valid = 1'b0;
                data_in  = 32'h0;
            end
            #1;
            if (out_valid) begin
                nvalid++;
                if (first < 0) first = cyc;
                last_c = cyc;
            end
            if (out_valid && out_ready) begin
                got = {out_row_id, out_last, out_idx, out_data};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %h expected none", got);
                end else begin
                    check("beat", 32'(got), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) void'(feed_q.pop_front());
            cyc++;
        end
        check("beats_pending", 32'(exp_q.size()), 32'd0);
        check("rows_pending", 32'(feed_q.size()), 32'd0);
        exp_q.delete();
        feed_q.delete();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        span = (first < 0) ? 0 : (last_c - first + 1);
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check("idle_valid", {31'd0, out_valid}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out", {20'd0, out_valid, out_last, out_idx, out_data}, 32'd0);
        check("rst_row_id", {24'd0, out_row_id}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = 32'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int nvalid;
        int span;
        logic [31:0] r;

        // Reset state.
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Three rows back to back, consumer always ready.
        tbl.push_back('{w: '{8'd0, 8'd1, 8'd0, 8'd2}, n: 2,
                        d: '{8'd1, 8'd2, 8'd0, 8'd0}, ix: '{2'd1, 2'd3, 2'd0, 2'd0}});
        tbl.push_back('{w: '{8'd0, 8'd0, 8'd3, 8'd4}, n: 2,
                        d: '{8'd3, 8'd4, 8'd0, 8'd0}, ix: '{2'd2, 2'd3, 2'd0, 2'd0}});
        tbl.push_back('{w: '{8'd5, 8'd6, 8'd0, 8'd7}, n: 3,
                        d: '{8'd5, 8'd6, 8'd7, 8'd0}, ix: '{2'd0, 2'd1, 2'd3, 2'd0}});
        load_table(0);
        run(0, 100, nvalid, span);
        check("stream_valid_cycles", 32'(nvalid), 32'd7);
        check("stream_span", 32'(span), 32'd7);
        expect_idle(2);

        // All-zero row followed by a single-word row.
        do_reset();
`ifdef RNZS_ZERO_ROW_BEAT_EN
        tbl.push_back('{w: '{8'd0, 8'd0, 8'd0, 8'd0}, n: 1,
                        d: '{8'd0, 8'd0, 8'd0, 8'd0}, ix: '{2'd0, 2'd0, 2'd0, 2'd0}});
`else
        tbl.push_back('{w: '{8'd0, 8'd0, 8'd0, 8'd0}, n: 0,
                        d: '{8'd0, 8'd0, 8'd0, 8'd0}, ix: '{2'd0, 2'd0, 2'd0, 2'd0}});
`endif
        tbl.push_back('{w: '{8'd0, 8'd0, 8'd8, 8'd0}, n: 1,
                        d: '{8'd8, 8'd0, 8'd0, 8'd0}, ix: '{2'd2, 2'd0, 2'd0, 2'd0}});
        load_table(0);
        run(0, 50, nvalid, span);
        expect_idle(2);

        // Stall on the second beat for three cycles.
        do_reset();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; data_in = mkrow(8'd5, 8'd6, 8'd0, 8'd7);
        #1;
        check("stall_accept_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b1; data_in = mkrow(8'd9, 8'd9, 8'd9, 8'd9);
        #1;
        check("stall_beat0", {19'd0, in_ready, out_valid, out_last, out_idx, out_data},
              {19'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd5});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            check("stall_hold", {11'd0, in_ready, out_row_id, out_valid, out_last, out_idx, out_data},
                  {11'd0, 1'b0, 8'd0, 1'b1, 1'b0, 2'd1, 8'd6});
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        #1;
        check("stall_beat1", {20'd0, out_valid, out_last, out_idx, out_data},
              {20'd0, 1'b1, 1'b0, 2'd1, 8'd6});
        @(negedge clk);
        #1;
        check("stall_beat2", {20'd0, out_valid, out_last, out_idx, out_data},
              {20'd0, 1'b1, 1'b1, 2'd3, 8'd7});
        expect_idle(3);

        // Row tag wraps after 256 rows.
        do_reset();
        for (int k = 0; k < 257; k++) begin
            feed_q.push_back(mkrow(8'd1, 8'd0, 8'd0, 8'd0));
            model_row(mkrow(8'd1, 8'd0, 8'd0, 8'd0), 8'(k));
        end
        run(0, 600, nvalid, span);
        check("wrap_valid_cycles", 32'(nvalid), 32'd257);

        // Asynchronous reset in the middle of a row.
        do_reset();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; data_in = mkrow(8'd5, 8'd6, 8'd0, 8'd7);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid_beat0", {24'd0, out_data}, 32'd5);
        @(negedge clk);
        #1;
        check("mid_beat1", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'd6});
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        expect_idle(3);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        feed_q.push_back(mkrow(8'd1, 8'd0, 8'd0, 8'd0));
        model_row(mkrow(8'd1, 8'd0, 8'd0, 8'd0), 8'd0);
        run(0, 20, nvalid, span);
        expect_idle(2);

        // Random rows with a randomly stalling consumer.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            r = 32'h0;
            if (k % 7 != 3) begin
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 2) != 0) r[8*i +: 8] = 8'($urandom_range(1, 255));
                end
            end
            feed_q.push_back(r);
            model_row(r, 8'(k));
        end
        run(1, 2000, nvalid, span);
        expect_idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
